// File: rtl/cam_arb_pkg.sv
// Shared state encoding and helpers for the CAM lookup arbiter.
package cam_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    RESP    = ST_RESP
  } state_e;

  localparam int MAX_CNT_WIDTH = 32;

  // Counters narrower than MAX_CNT_WIDTH are widened by the caller; max_value marks saturation.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] value,
    input logic [MAX_CNT_WIDTH-1:0] max_value,
    input logic                     en
  );
    if (en && (value != max_value)) begin
      return value + MAX_CNT_WIDTH'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick starting after the last winner,
// with the pointer register advanced only when the pick is consumed.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                advance_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                any_o
);

  logic [ID_WIDTH-1:0] last_q, last_d;
  int                  scan_idx;

  always_comb begin
    gnt_o    = '0;
    id_o     = '0;
    any_o    = 1'b0;
    scan_idx = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = (int'(last_q) + off) % NUM_REQ;
      if (!any_o && req_i[scan_idx]) begin
        any_o           = 1'b1;
        id_o            = ID_WIDTH'(scan_idx);
        gnt_o[scan_idx] = 1'b1;
      end
    end
  end

  assign last_d = (advance_i && any_o) ? id_o : last_q;

  // Reset points at the highest index so requester 0 wins the first round.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cam_lookup_arbiter.sv
// Shares one registered CAM match/priority-encode stage among NUM_REQ
// requesters and returns tagged responses plus saturating statistics.
module cam_lookup_arbiter
  import cam_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*DEPTH-1:0] req_match_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     cam_enable_o,
  output logic [DEPTH-1:0]         cam_data_in_o,
  input  logic                     cam_hit_out_i,
  input  logic [ADDR_WIDTH-1:0]    cam_addr_out_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_hit_o,
  output logic [ADDR_WIDTH-1:0]    resp_addr_o,
  output logic [ID_WIDTH-1:0]      resp_id_o,
  output logic [CNT_WIDTH-1:0]     lookup_cnt_o,
  output logic [CNT_WIDTH-1:0]     hit_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [ID_WIDTH-1:0]     arb_id;
  logic                    arb_any;
  logic                    arb_advance;
  logic                    arbitrate;

  logic [NUM_REQ-1:0]      gnt_vec_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DEPTH-1:0]        vec_q;
  logic                    resp_hit_q;
  logic [ADDR_WIDTH-1:0]   resp_addr_q;
  logic [ID_WIDTH-1:0]     resp_id_q;
  logic [CNT_WIDTH-1:0]    lookup_cnt_q, lookup_cnt_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;

  // A new winner is taken from IDLE, or from RESP in the same edge the response is accepted.
  assign arb_advance = (state_q == IDLE) || ((state_q == RESP) && resp_ready_i);
  assign arbitrate   = arb_advance && arb_any;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .advance_i (arb_advance),
    .gnt_o     (arb_gnt),
    .id_o      (arb_id),
    .any_o     (arb_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (resp_ready_i) state_d = arb_any ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o         = '0;
    cam_enable_o  = 1'b0;
    cam_data_in_o = '0;
    resp_valid_o  = 1'b0;
    case (state_q)
      ISSUE: begin
        gnt_o         = gnt_vec_q;
        cam_enable_o  = 1'b1;
        cam_data_in_o = vec_q;
      end
      RESP:    resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign lookup_cnt_d = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(lookup_cnt_q),
                                           MAX_CNT_WIDTH'(CNT_MAX), 1'b1));
  assign hit_cnt_d    = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(hit_cnt_q),
                                           MAX_CNT_WIDTH'(CNT_MAX), cam_hit_out_i));

  // The match vector is frozen at the arbitration edge; the CAM result is taken in CAPTURE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_vec_q    <= '0;
      id_q         <= '0;
      vec_q        <= '0;
      resp_hit_q   <= 1'b0;
      resp_addr_q  <= '0;
      resp_id_q    <= '0;
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      if (arbitrate) begin
        gnt_vec_q <= arb_gnt;
        id_q      <= arb_id;
        vec_q     <= req_match_i[arb_id*DEPTH +: DEPTH];
      end
      if (state_q == CAPTURE) begin
        resp_hit_q   <= cam_hit_out_i;
        resp_addr_q  <= cam_addr_out_i;
        resp_id_q    <= id_q;
        lookup_cnt_q <= lookup_cnt_d;
        hit_cnt_q    <= hit_cnt_d;
      end
    end
  end

  assign resp_hit_o   = resp_hit_q;
  assign resp_addr_o  = resp_addr_q;
  assign resp_id_o    = resp_id_q;
  assign lookup_cnt_o = lookup_cnt_q;
  assign hit_cnt_o    = hit_cnt_q;

endmodule

// File: doc/cam_lookup_arbiter.md
Name: cam_lookup_arbiter

Overview:
- Shares one `cam` match/priority-encode stage among NUM_REQ requesters.
- Round-robin arbitration selects one requester, which supplies its DEPTH-bit match vector.
- The block drives `cam_enable`/`cam_data_in`, captures the CAM's registered `cam_hit_out`/`cam_addr_out` one cycle later, and returns a tagged response over a valid/ready handshake.
- Also keeps saturating lookup and hit statistics counters.

Parameters:
- ADDR_WIDTH, 8, CAM address width.
- DEPTH, 1 << ADDR_WIDTH, CAM entries (width of match vector).
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, $clog2(NUM_REQ), width of requester tag.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester lookup request; held until matching gnt bit seen.
- req_match  in  NUM_REQ*DEPTH  flattened match vectors; requester k occupies bits [k*DEPTH +: DEPTH].
- gnt  out  NUM_REQ  one-hot, one-cycle registered grant pulse.
- cam_enable  out  1  to CAM.
- cam_data_in  out  DEPTH  to CAM.
- cam_hit_out  in  1  from CAM (registered output).
- cam_addr_out  in  ADDR_WIDTH  from CAM (registered output).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_hit  out  1  lookup hit.
- resp_addr  out  ADDR_WIDTH  matched address (lowest set bit of the match vector).
- resp_id  out  ID_WIDTH  index of the granted requester.
- lookup_cnt  out  CNT_WIDTH  completed lookups; saturating.
- hit_cnt  out  CNT_WIDTH  completed hits; saturating.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - All outputs 0: gnt, cam_enable, cam_data_in, resp_*, both counters.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Any in-flight lookup is discarded silently: no gnt re-issue, no resp.
- State IDLE:
  - If req != 0, pick the first set req bit searching last+1, last+2, ... (mod NUM_REQ).
  - At the edge: latch id and req_match[id], set last=id, go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE (1 cycle):
  - gnt[id]=1.
  - cam_enable=1, cam_data_in=latched vector.
  - Next state CAPTURE.
- State CAPTURE (1 cycle):
  - cam_enable=0, cam_data_in=0.
  - cam_hit_out/cam_addr_out reflect the ISSUE vector.
  - At the edge: resp_hit<=cam_hit_out, resp_addr<=cam_addr_out, resp_id<=id.
  - lookup_cnt += 1 and hit_cnt += cam_hit_out, each saturating at all-ones.
  - Next state RESP.
- State RESP:
  - resp_valid=1; resp_* stay stable until resp_valid && resp_ready.
  - On handshake with req != 0: arbitrate exactly as in IDLE and go straight to ISSUE.
  - On handshake with req == 0: go to IDLE.
  - Without handshake: stay in RESP. No gnt, cam_enable stays 0.
- Latency: req sampled in cycle 0, gnt/cam_enable in cycle 1, resp_valid in cycle 3. Maximum throughput is 1 lookup per 3 cycles.
- gnt and cam_enable are never asserted outside ISSUE.
- At most one lookup is outstanding.
- A requester dropping req before gnt is legal; it only takes effect at the next arbitration.
- req_match is sampled only at the arbitration edge; changes after that edge are ignored.
- resp_addr is taken from the CAM unchanged. On a miss, the CAM returns 0, and so does the block.

Decomposition:
- Package `cam_arb_pkg` holds:
  - the state enum IDLE/ISSUE/CAPTURE/RESP;
  - the 2-bit state encoding constants;
  - the saturating-increment function.
- One natural sub-module: `rr_arbiter`, parameterised by NUM_REQ.
  - Inputs: req, last, advance.
  - Outputs: one-hot grant, binary id, any.
  - Purely combinational apart from the pointer register.

Test Plan (ADDR_WIDTH=3, DEPTH=8, NUM_REQ=4):
1. Reset: hold rst=1 for 2 cycles with req=4'hF -> all outputs 0, gnt never asserted. After release, first grant goes to req0.
2. Single lookup: req0, match 8'h24, resp_ready=1 -> gnt=4'b0001 and cam_enable=1 with data 8'h24 in cycle 1; resp_valid in cycle 3 with hit=1, addr=2, id=0; lookup_cnt=1, hit_cnt=1.
3. Fairness: req=4'hF held continuously, resp_ready=1 -> grants 0,1,2,3,0 spaced exactly 3 cycles apart; resp_id follows the same order.
4. Backpressure: resp_ready=0 for 5 cycles during RESP with req1 pending -> resp_valid and resp_* stable, no gnt, cam_enable=0. gnt[1] appears 1 cycle after resp_ready rises.
5. Miss plus saturation: match 8'h00 -> resp_hit=0, addr=0, hit_cnt unchanged, lookup_cnt+1. Preload lookup_cnt to 16'hFFFF via a force and do one more lookup -> stays 16'hFFFF.
6. Reset mid-op: assert rst during CAPTURE -> next cycle IDLE, resp_valid stays 0, counters 0. After release, a req2-only request gets gnt[2] with the normal 1-cycle latency.
